// File: rtl/conv_edge_stream.sv
// Streaming 3x3 Sobel/Prewitt gradient edge detector.
// Four-stage pipeline with a global stall and a saturating edge counter.
module conv_edge_stream #(
  parameter int PIXEL_W = 8,
  parameter int SUM_W   = PIXEL_W + 3,
  parameter int MAG_W   = 2 * SUM_W,
  parameter int CNT_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [9*PIXEL_W-1:0] i_pixel_data,
  input  logic                 i_pixel_data_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_mode,
  input  logic [MAG_W-1:0]     i_threshold,
  output logic [PIXEL_W-1:0]   o_convolved_data,
  output logic                 o_convolved_data_valid,
  input  logic                 i_ready,
  input  logic                 i_count_clr,
  output logic [CNT_W-1:0]     o_edge_count
);

  logic w_adv;

  logic                 r1_v;
  logic [9*PIXEL_W-1:0] r1_win;
  logic [1:0]           r1_mode;
  logic [MAG_W-1:0]     r1_thr;

  logic                    r2_v;
  logic signed [SUM_W-1:0] r2_gx;
  logic signed [SUM_W-1:0] r2_gy;
  logic                    r2_l1m;
  logic [MAG_W-1:0]        r2_thr;

  logic               r3_v;
  logic [MAG_W-1:0]   r3_sq;
  logic [SUM_W-1:0]   r3_l1;
  logic               r3_l1m;
  logic [MAG_W-1:0]   r3_thr;

  logic               r4_v;
  logic [PIXEL_W-1:0] r4_out;
  logic               r4_edge;
  logic [CNT_W-1:0]   r_cnt;

  logic signed [SUM_W-1:0] w_p [9];
  logic signed [SUM_W-1:0] w_c3;
  logic signed [SUM_W-1:0] w_c5;
  logic signed [SUM_W-1:0] w_c1;
  logic signed [SUM_W-1:0] w_c7;
  logic signed [SUM_W-1:0] w_gx;
  logic signed [SUM_W-1:0] w_gy;

  logic signed [MAG_W-1:0] w_gxe;
  logic signed [MAG_W-1:0] w_gye;
  logic signed [MAG_W-1:0] w_sq_s;
  logic [MAG_W-1:0]        w_sq;
  logic [SUM_W-1:0]        w_ax;
  logic [SUM_W-1:0]        w_ay;
  logic [SUM_W-1:0]        w_l1;

  logic               w_edge;
  logic               w_sat;
  logic [PIXEL_W-1:0] w_out;
  logic               w_inc;

  // All stages share one enable, so the output holds until accepted
  assign w_adv   = !r4_v || i_ready;
  assign o_ready = w_adv;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_p[k] = $signed({{(SUM_W-PIXEL_W){1'b0}},
                        r1_win[k*PIXEL_W +: PIXEL_W]});
    end
  end

  assign w_c3 = r1_mode[1] ? w_p[3] : (w_p[3] <<< 1);
  assign w_c5 = r1_mode[1] ? w_p[5] : (w_p[5] <<< 1);
  assign w_c1 = r1_mode[1] ? w_p[1] : (w_p[1] <<< 1);
  assign w_c7 = r1_mode[1] ? w_p[7] : (w_p[7] <<< 1);

  assign w_gx = w_p[0] - w_p[2] + w_c3 - w_c5 + w_p[6] - w_p[8];
  assign w_gy = w_p[0] + w_c1 + w_p[2] - w_p[6] - w_c7 - w_p[8];

  assign w_gxe  = {{(MAG_W-SUM_W){r2_gx[SUM_W-1]}}, r2_gx};
  assign w_gye  = {{(MAG_W-SUM_W){r2_gy[SUM_W-1]}}, r2_gy};
  assign w_sq_s = w_gxe * w_gxe + w_gye * w_gye;
  assign w_sq   = $unsigned(w_sq_s);

  assign w_ax = r2_gx[SUM_W-1] ? $unsigned(-r2_gx) : $unsigned(r2_gx);
  assign w_ay = r2_gy[SUM_W-1] ? $unsigned(-r2_gy) : $unsigned(r2_gy);
  assign w_l1 = w_ax + w_ay;

  assign w_edge = r3_sq > r3_thr;
  assign w_sat  = |r3_l1[SUM_W-1:PIXEL_W];
  assign w_out  = r3_l1m ? (w_sat ? {PIXEL_W{1'b1}} : r3_l1[PIXEL_W-1:0])
                         : {PIXEL_W{w_edge}};

  assign w_inc = r4_v && i_ready && r4_edge && (r_cnt != {CNT_W{1'b1}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_v    <= 1'b0;
      r1_win  <= '0;
      r1_mode <= '0;
      r1_thr  <= '0;
      r2_v    <= 1'b0;
      r2_gx   <= '0;
      r2_gy   <= '0;
      r2_l1m  <= 1'b0;
      r2_thr  <= '0;
      r3_v    <= 1'b0;
      r3_sq   <= '0;
      r3_l1   <= '0;
      r3_l1m  <= 1'b0;
      r3_thr  <= '0;
      r4_v    <= 1'b0;
      r4_out  <= '0;
      r4_edge <= 1'b0;
    end else if (w_adv) begin
      r1_v    <= i_pixel_data_valid;
      r1_win  <= i_pixel_data;
      r1_mode <= i_mode;
      r1_thr  <= i_threshold;
      r2_v    <= r1_v;
      r2_gx   <= w_gx;
      r2_gy   <= w_gy;
      r2_l1m  <= r1_mode[0];
      r2_thr  <= r1_thr;
      r3_v    <= r2_v;
      r3_sq   <= w_sq;
      r3_l1   <= w_l1;
      r3_l1m  <= r2_l1m;
      r3_thr  <= r2_thr;
      r4_v    <= r3_v;
      r4_out  <= w_out;
      r4_edge <= r3_v && !r3_l1m && w_edge;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_count_clr) begin
      r_cnt <= '0;
    end else if (w_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_convolved_data       = r4_out;
  assign o_convolved_data_valid = r4_v;
  assign o_edge_count           = r_cnt;

endmodule

// File: tb/tb_conv_edge_stream.sv
// Directed self-checking bench for conv_edge_stream.
// Each scenario task drives stimulus and checks results inline.
module tb_conv_edge_stream;

  localparam int PW = 8;
  localparam int MW = 22;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic [9*PW-1:0] pix;
  logic          pix_v;
  logic          o_rdy;
  logic [1:0]    mode;
  logic [MW-1:0] thr;
  logic [PW-1:0] odat;
  logic          ov;
  logic          drdy;
  logic          clr;
  logic [CW-1:0] cnt;

  int tests_run = 0;
  int failed    = 0;
  int exp_cnt   = 0;

  conv_edge_stream #(.PIXEL_W(PW)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_pixel_data           (pix),
    .i_pixel_data_valid     (pix_v),
    .o_ready                (o_rdy),
    .i_mode                 (mode),
    .i_threshold            (thr),
    .o_convolved_data       (odat),
    .o_convolved_data_valid (ov),
    .i_ready                (drdy),
    .i_count_clr            (clr),
    .o_edge_count           (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9*PW-1:0] px1(input int k, input logic [PW-1:0] v);
    logic [9*PW-1:0] w;
    w = '0;
    w[k*PW +: PW] = v;
    return w;
  endfunction

  function automatic logic [9*PW-1:0] left_col();
    return px1(0, 8'hFF) | px1(3, 8'hFF) | px1(6, 8'hFF);
  endfunction

  task automatic do_beat(input logic [9*PW-1:0] w, input logic [1:0] m,
                         input logic [MW-1:0] t, input logic c,
                         output logic v3, output logic v4,
                         output logic [PW-1:0] d);
    @(negedge clk);
    pix = w; mode = m; thr = t; pix_v = 1'b1;
    @(posedge clk); #1 pix_v = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 v3 = ov;
    @(posedge clk); #1 v4 = ov; d = odat; clr = c;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ov, odat, cnt, o_rdy} !== {1'b0, 8'h00, 32'd0, 1'b1}) begin
      failed++;
      $display("FAIL reset_state: v=%b d=%h cnt=%0d rdy=%b, want 0 00 0 1",
               ov, odat, cnt, o_rdy);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_rdy !== 1'b1 || ov !== 1'b0) begin
      failed++;
      $display("FAIL post_reset: rdy=%b v=%b, want 1 0", o_rdy, ov);
    end
  endtask

  task automatic test_uniform();
    logic [9*PW-1:0] w;
    logic v3, v4;
    logic [PW-1:0] d;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = 8'd100;
    do_beat(w, 2'b00, 22'd4000, 1'b0, v3, v4, d);
    tests_run++;
    if ({v3, v4} !== 2'b01) begin
      failed++;
      $display("FAIL latency: v@3=%b v@4=%b, want 0 1", v3, v4);
    end
    tests_run++;
    if (d !== 8'h00) begin
      failed++;
      $display("FAIL uniform_bin: got %h want 00", d);
    end
    do_beat(w, 2'b01, 22'd4000, 1'b0, v3, v4, d);
    tests_run++;
    if (v4 !== 1'b1 || d !== 8'h00) begin
      failed++;
      $display("FAIL uniform_l1: v=%b got %h want 1 00", v4, d);
    end
  endtask

  task automatic test_left_col();
    logic v3, v4;
    logic [PW-1:0] d;
    do_beat(left_col(), 2'b00, 22'd4000, 1'b0, v3, v4, d);
    exp_cnt++;
    tests_run++;
    if (v4 !== 1'b1 || d !== 8'hFF) begin
      failed++;
      $display("FAIL leftcol_bin: v=%b got %h want 1 ff", v4, d);
    end
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL leftcol_cnt: got %0d want %0d", cnt, exp_cnt);
    end
    do_beat(left_col(), 2'b01, 22'd4000, 1'b0, v3, v4, d);
    tests_run++;
    if (v4 !== 1'b1 || d !== 8'hFF) begin
      failed++;
      $display("FAIL leftcol_l1_sat: v=%b got %h want 1 ff", v4, d);
    end
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL l1_no_count: got %0d want %0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_p2();
    logic v3, v4;
    logic [PW-1:0] d;
    do_beat(px1(2, 8'd10), 2'b00, 22'd200, 1'b0, v3, v4, d);
    tests_run++;
    if (d !== 8'h00) begin
      failed++;
      $display("FAIL thr_equal: got %h want 00", d);
    end
    do_beat(px1(2, 8'd10), 2'b00, 22'd199, 1'b0, v3, v4, d);
    exp_cnt++;
    tests_run++;
    if (d !== 8'hFF) begin
      failed++;
      $display("FAIL thr_below: got %h want ff", d);
    end
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL p2_cnt: got %0d want %0d", cnt, exp_cnt);
    end
    do_beat(px1(2, 8'd10), 2'b01, 22'd0, 1'b0, v3, v4, d);
    tests_run++;
    if (d !== 8'h14) begin
      failed++;
      $display("FAIL p2_sobel_l1: got %h want 14", d);
    end
    do_beat(px1(2, 8'd10), 2'b11, 22'd0, 1'b0, v3, v4, d);
    tests_run++;
    if (d !== 8'h14) begin
      failed++;
      $display("FAIL p2_prewitt_l1: got %h want 14", d);
    end
    do_beat(left_col(), 2'b10, 22'd600000, 1'b0, v3, v4, d);
    tests_run++;
    if (d !== 8'h00) begin
      failed++;
      $display("FAIL prewitt_bin: got %h want 00", d);
    end
    do_beat(left_col(), 2'b10, 22'd585224, 1'b0, v3, v4, d);
    exp_cnt++;
    tests_run++;
    if (d !== 8'hFF) begin
      failed++;
      $display("FAIL prewitt_bin_lo: got %h want ff", d);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] vals [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [1:0]    mds  [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [MW-1:0] ths  [8] = '{22'd1, 22'd0, 22'd18, 22'd0, 22'd49, 22'd0, 22'd100, 22'd0};
    logic [PW-1:0] expd [8] = '{8'hFF, 8'h04, 8'h00, 8'h08, 8'hFF, 8'h0C, 8'h00, 8'h10};
    int sent, got, stall;
    bit first, acc;
    logic [PW-1:0] held;
    sent = 0; got = 0; stall = 0; first = 0; held = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      if (ov && !first) begin
        first = 1; stall = 3; held = odat;
      end
      drdy  = (stall == 0);
      pix_v = (sent < 8);
      if (sent < 8) begin
        pix = px1(2, vals[sent]); mode = mds[sent]; thr = ths[sent];
      end
      #1;
      if (stall > 0) begin
        tests_run++;
        if (o_rdy !== 1'b0) begin
          failed++;
          $display("FAIL stall_ready: got %b want 0", o_rdy);
        end
        tests_run++;
        if (ov !== 1'b1 || odat !== held) begin
          failed++;
          $display("FAIL stall_hold: v=%b d=%h want 1 %h", ov, odat, held);
        end
        stall--;
      end
      if (drdy && ov) begin
        tests_run++;
        if (odat !== expd[got]) begin
          failed++;
          $display("FAIL bp_out%0d: got %h want %h", got, odat, expd[got]);
        end
        got++;
      end
      acc = pix_v && o_rdy;
      @(posedge clk);
      if (acc) sent++;
    end
    #1;
    pix_v = 1'b0;
    drdy  = 1'b1;
    exp_cnt += 2;
    tests_run++;
    if (got !== 8) begin
      failed++;
      $display("FAIL bp_count: delivered %0d want 8", got);
    end
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL bp_edges: got %0d want %0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    logic v3, v4;
    logic [PW-1:0] d;
    bit seen;
    @(negedge clk);
    pix = left_col(); mode = 2'b00; thr = 22'd4000; pix_v = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 pix_v = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({ov, odat, cnt} !== {1'b0, 8'h00, 32'd0}) begin
      failed++;
      $display("FAIL rst_flight: v=%b d=%h cnt=%0d want 0 00 0", ov, odat, cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov) seen = 1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      failed++;
      $display("FAIL rst_discard: ghost beat seen=%b want 0", seen);
    end
    do_beat(left_col(), 2'b00, 22'd4000, 1'b0, v3, v4, d);
    exp_cnt++;
    tests_run++;
    if ({v3, v4, d} !== {2'b01, 8'hFF}) begin
      failed++;
      $display("FAIL rst_next: v3=%b v4=%b d=%h want 0 1 ff", v3, v4, d);
    end
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL rst_next_cnt: got %0d want %0d", cnt, exp_cnt);
    end
  endtask

  task automatic test_count_clr();
    logic v3, v4;
    logic [PW-1:0] d;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_cnt = 0;
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL clr_alone: got %0d want 0", cnt);
    end
    for (int i = 0; i < 5; i++) begin
      do_beat(left_col(), 2'b00, 22'd4000, 1'b0, v3, v4, d);
      exp_cnt++;
    end
    tests_run++;
    if (cnt !== 32'd5) begin
      failed++;
      $display("FAIL preload: got %0d want 5", cnt);
    end
    do_beat(left_col(), 2'b00, 22'd4000, 1'b1, v3, v4, d);
    exp_cnt = 0;
    tests_run++;
    if (cnt !== exp_cnt) begin
      failed++;
      $display("FAIL clr_priority: got %0d want 0", cnt);
    end
    do_beat(left_col(), 2'b00, 22'd4000, 1'b0, v3, v4, d);
    exp_cnt++;
    tests_run++;
    if (cnt !== 32'd1) begin
      failed++;
      $display("FAIL after_clr: got %0d want 1", cnt);
    end
  endtask

  initial begin
    rst   = 1'b0;
    pix   = '0;
    pix_v = 1'b0;
    mode  = 2'b00;
    thr   = '0;
    drdy  = 1'b1;
    clr   = 1'b0;
    test_reset();
    test_uniform();
    test_left_col();
    test_p2();
    test_backpressure();
    test_reset_inflight();
    test_count_clr();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
